// File: rtl/packet_priority_classifier.sv
// Buffers each frame's header, classifies on the IPv4 precedence bits and
// forwards the whole frame to one of three priority egress streams.
module packet_priority_classifier #(
  parameter int AXIS_DATA_WIDTH  = 64,
  parameter int AXIS_KEEP_WIDTH  = AXIS_DATA_WIDTH/8,
  parameter int PRIO_BYTE_OFFSET = 15,
  parameter int HIGH_THRESH      = 5,
  parameter int MID_THRESH       = 3,
  parameter int DEFAULT_CLASS    = 2,
  parameter int COUNT_WIDTH      = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [AXIS_DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [AXIS_KEEP_WIDTH-1:0]   s_axis_tkeep,
  input  logic                         s_axis_tvalid,
  output logic                         s_axis_tready,
  input  logic                         s_axis_tlast,
  output logic [3*AXIS_DATA_WIDTH-1:0] m_axis_priority_fifo_tdata,
  output logic [3*AXIS_KEEP_WIDTH-1:0] m_axis_priority_fifo_tkeep,
  output logic [2:0]                   m_axis_priority_fifo_tvalid,
  input  logic [2:0]                   m_axis_priority_fifo_tready,
  output logic [2:0]                   m_axis_priority_fifo_tlast,
  output logic [3*COUNT_WIDTH-1:0]     status_frame_count,
  output logic                         status_short_frame
);

  localparam int HDR_BEATS = PRIO_BYTE_OFFSET/AXIS_KEEP_WIDTH + 1;
  localparam int IW        = (HDR_BEATS > 1) ? $clog2(HDR_BEATS) : 1;
  localparam int DEPTH     = 2**IW;
  localparam int PB        = PRIO_BYTE_OFFSET % AXIS_KEEP_WIDTH;

  localparam logic [IW-1:0] LAST_IDX = IW'(HDR_BEATS-1);
  localparam logic [2:0]    HI_T     = 3'(HIGH_THRESH);
  localparam logic [2:0]    MID_T    = 3'(MID_THRESH);
  localparam logic [1:0]    DEF_CLS  = 2'(DEFAULT_CLASS);

  typedef enum logic [1:0] {HEADER, FLUSH, PASS} state_t;

  state_t               state_q, state_d;
  logic [IW-1:0]        wr_cnt_q, wr_cnt_d;
  logic [IW-1:0]        rd_cnt_q, rd_cnt_d;
  logic [IW-1:0]        last_q, last_d;
  logic [1:0]           sel_q, sel_d;
  logic                 short_q, short_d;

  logic [AXIS_DATA_WIDTH-1:0] buf_data_q [DEPTH];
  logic [AXIS_KEEP_WIDTH-1:0] buf_keep_q [DEPTH];
  logic                       buf_last_q [DEPTH];
  logic                       buf_we;

  logic [COUNT_WIDTH-1:0] cnt_q [3];

  logic [2:0]                 prec;
  logic                       prio_ok;
  logic [1:0]                 cls;
  logic                       out_v, out_rdy, out_l;
  logic [AXIS_DATA_WIDTH-1:0] out_d;
  logic [AXIS_KEEP_WIDTH-1:0] out_k;

  // The priority byte is only present when the trigger beat is the final header beat.
  always_comb begin
    prec    = s_axis_tdata[PB*8+5 +: 3];
    prio_ok = (wr_cnt_q == LAST_IDX) && s_axis_tkeep[PB];
    if (!prio_ok)           cls = DEF_CLS;
    else if (prec >= HI_T)  cls = 2'd0;
    else if (prec >= MID_T) cls = 2'd1;
    else                    cls = 2'd2;
  end

  assign out_rdy = m_axis_priority_fifo_tready[sel_q];

  always_comb begin
    state_d       = state_q;
    wr_cnt_d      = wr_cnt_q;
    rd_cnt_d      = rd_cnt_q;
    last_d        = last_q;
    sel_d         = sel_q;
    short_d       = 1'b0;
    buf_we        = 1'b0;
    s_axis_tready = 1'b0;
    out_v         = 1'b0;
    out_d         = buf_data_q[rd_cnt_q];
    out_k         = buf_keep_q[rd_cnt_q];
    out_l         = buf_last_q[rd_cnt_q];
    case (state_q)
      HEADER: begin
        s_axis_tready = 1'b1;
        if (s_axis_tvalid) begin
          buf_we   = 1'b1;
          wr_cnt_d = wr_cnt_q + 1'b1;
          if (wr_cnt_q == LAST_IDX || s_axis_tlast) begin
            sel_d    = cls;
            short_d  = ~prio_ok;
            rd_cnt_d = '0;
            last_d   = wr_cnt_q;
            state_d  = FLUSH;
          end
        end
      end
      FLUSH: begin
        out_v = 1'b1;
        if (out_rdy) begin
          rd_cnt_d = rd_cnt_q + 1'b1;
          if (rd_cnt_q == last_q) begin
            if (buf_last_q[rd_cnt_q]) begin
              state_d  = HEADER;
              wr_cnt_d = '0;
            end else begin
              state_d = PASS;
            end
          end
        end
      end
      PASS: begin
        out_v         = s_axis_tvalid;
        s_axis_tready = out_rdy;
        out_d         = s_axis_tdata;
        out_k         = s_axis_tkeep;
        out_l         = s_axis_tlast;
        if (s_axis_tvalid && out_rdy && s_axis_tlast) begin
          state_d  = HEADER;
          wr_cnt_d = '0;
        end
      end
      default: state_d = HEADER;
    endcase
    if (rst) begin
      s_axis_tready = 1'b0;
      out_v         = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= HEADER;
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
      last_q   <= '0;
      sel_q    <= '0;
      short_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
      last_q   <= last_d;
      sel_q    <= sel_d;
      short_q  <= short_d;
    end
  end

  always_ff @(posedge clk) begin
    if (buf_we) begin
      buf_data_q[wr_cnt_q] <= s_axis_tdata;
      buf_keep_q[wr_cnt_q] <= s_axis_tkeep;
      buf_last_q[wr_cnt_q] <= s_axis_tlast;
    end
  end

  always_comb begin
    for (int unsigned k = 0; k < 3; k++) begin
      m_axis_priority_fifo_tdata[k*AXIS_DATA_WIDTH +: AXIS_DATA_WIDTH] = out_d;
      m_axis_priority_fifo_tkeep[k*AXIS_KEEP_WIDTH +: AXIS_KEEP_WIDTH] = out_k;
      m_axis_priority_fifo_tlast[k]  = out_l;
      m_axis_priority_fifo_tvalid[k] = out_v && (sel_q == 2'(k));
      status_frame_count[k*COUNT_WIDTH +: COUNT_WIDTH] = rst ? '0 : cnt_q[k];
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned k = 0; k < 3; k++) begin
      if (rst)
        cnt_q[k] <= '0;
      else if (m_axis_priority_fifo_tvalid[k] && m_axis_priority_fifo_tready[k] && out_l)
        cnt_q[k] <= cnt_q[k] + 1'b1;
    end
  end

  assign status_short_frame = short_q & ~rst;

endmodule

// File: tb/tb_packet_priority_classifier.sv
// Directed and randomized checks of the priority classifier with 64-bit data
// and 4-bit counters so that counter wrap is reachable.
module tb_packet_priority_classifier;
  localparam int DW = 64;
  localparam int KW = 8;
  localparam int CW = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [DW-1:0]   s_tdata;
  logic [KW-1:0]   s_tkeep;
  logic            s_tvalid, s_tready, s_tlast;
  logic [3*DW-1:0] m_tdata;
  logic [3*KW-1:0] m_tkeep;
  logic [2:0]      m_tvalid, m_tready, m_tlast;
  logic [3*CW-1:0] frame_count;
  logic            short_frame;

  always #5 clk = ~clk;

  packet_priority_classifier #(.AXIS_DATA_WIDTH(DW), .COUNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_tready), .s_axis_tlast(s_tlast),
    .m_axis_priority_fifo_tdata(m_tdata), .m_axis_priority_fifo_tkeep(m_tkeep),
    .m_axis_priority_fifo_tvalid(m_tvalid), .m_axis_priority_fifo_tready(m_tready),
    .m_axis_priority_fifo_tlast(m_tlast),
    .status_frame_count(frame_count), .status_short_frame(short_frame)
  );

  typedef struct packed {
    logic [1:0]    cls;
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic          l;
  } beat_t;

  beat_t exp_q[$];
  beat_t got_q[$];
  beat_t mon_b;
  int checks = 0, errors = 0;
  int viol = 0, short_seen = 0;
  int viol_base, short_base, short_exp;
  int cnt_m[3];
  int fid = 0;
  logic rdy_rand = 1'b0, rdy_manual = 1'b0;
  logic [2:0] prev_v, prev_hs;
  logic [DW-1:0] prev_d;
  logic prev_rst = 1'b1;

  always @(posedge clk) begin
    #1;
    if (!rdy_manual) m_tready = rdy_rand ? 3'($urandom_range(0, 7)) : 3'b111;
  end

  // Egress monitor: records handshakes, flags protocol violations.
  always @(negedge clk) begin
    if (!rst) begin
      if ($countones(m_tvalid) > 1) viol <= viol + 1;
      if (m_tvalid != 3'b000 &&
          (m_tdata[63:0] !== m_tdata[127:64] || m_tdata[63:0] !== m_tdata[191:128] ||
           m_tkeep[7:0] !== m_tkeep[15:8] || m_tkeep[7:0] !== m_tkeep[23:16] ||
           m_tlast[0] !== m_tlast[1] || m_tlast[0] !== m_tlast[2]))
        viol <= viol + 1;
      for (int k = 0; k < 3; k++) begin
        if (m_tvalid[k] && m_tready[k]) begin
          mon_b.cls = 2'(k);
          mon_b.d   = m_tdata[k*DW +: DW];
          mon_b.k   = m_tkeep[k*KW +: KW];
          mon_b.l   = m_tlast[k];
          got_q.push_back(mon_b);
        end
        if (!prev_rst && prev_v[k] && !prev_hs[k] &&
            (!m_tvalid[k] || m_tdata[k*DW +: DW] !== prev_d))
          viol <= viol + 1;
      end
      if (short_frame) short_seen <= short_seen + 1;
    end
    prev_v   <= m_tvalid;
    prev_hs  <= m_tvalid & m_tready;
    prev_d   <= m_tdata[63:0];
    prev_rst <= rst;
  end

  task automatic do_reset();
    rst = 1'b1;
    s_tvalid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    got_q.delete();
    cnt_m = '{0, 0, 0};
    short_exp = 0;
    @(negedge clk);
    short_base = short_seen;
    viol_base  = viol;
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [DW-1:0] d, input logic [KW-1:0] k,
                           input logic l, input int idle);
    logic hs;
    hs = 1'b0;
    s_tvalid = 1'b0;
    repeat (idle) begin @(posedge clk); #1; end
    s_tdata = d; s_tkeep = k; s_tlast = l; s_tvalid = 1'b1;
    for (int c = 0; c < 300 && !hs; c++) begin
      @(negedge clk);
      hs = s_tready;
      @(posedge clk);
      #1;
    end
    checks++;
    if (!hs) begin
      errors++;
      $display("FAIL ingress_timeout: tready never seen for beat %h", d);
    end
    s_tvalid = 1'b0;
  endtask

  function automatic logic [DW-1:0] beat_data(input logic [7:0] tos, input int i, input int f);
    return {(i == 1) ? tos : 8'h5A, 24'(f), 32'(i)};
  endfunction

  task automatic send_frame(input logic [7:0] tos, input int n, input logic [KW-1:0] keep_last,
                            input int idle_max);
    logic [KW-1:0] k1;
    logic          short;
    logic [2:0]    p;
    logic [1:0]    c;
    beat_t         b;
    k1 = (n == 2) ? keep_last : 8'hFF;
    short = (n < 2) || !k1[7];
    p = tos[7:5];
    c = short ? 2'd2 : (p >= 3'd5) ? 2'd0 : (p >= 3'd3) ? 2'd1 : 2'd2;
    for (int i = 0; i < n; i++) begin
      b.cls = c;
      b.d   = beat_data(tos, i, fid);
      b.k   = (i == n-1) ? keep_last : 8'hFF;
      b.l   = (i == n-1);
      exp_q.push_back(b);
      send_beat(b.d, b.k, b.l, (idle_max > 0) ? $urandom_range(0, idle_max) : 0);
    end
    cnt_m[c] = (cnt_m[c] + 1) % (1 << CW);
    if (short) short_exp++;
    fid++;
  endtask

  task automatic wait_drain(output bit ok);
    int c;
    for (c = 0; c < 1000 && got_q.size() < exp_q.size(); c++) begin
      @(posedge clk); #1;
    end
    ok = (c < 1000);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; s_tvalid = 1'b0; s_tdata = '0; s_tkeep = '0; s_tlast = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (s_tready !== 1'b0) begin errors++; $display("FAIL reset_s_tready: got %b want 0", s_tready); end
    checks++; if (m_tvalid !== 3'b000) begin errors++; $display("FAIL reset_m_tvalid: got %b want 000", m_tvalid); end
    checks++; if (frame_count !== '0) begin errors++; $display("FAIL reset_counts: got %h want 0", frame_count); end
    checks++; if (short_frame !== 1'b0) begin errors++; $display("FAIL reset_short: got %b want 0", short_frame); end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (s_tready !== 1'b1) begin errors++; $display("FAIL reset_release_header: tready %b want 1", s_tready); end
  endtask

  task automatic test_high_priority();
    bit ok;
    beat_t b;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      b.cls = 2'd0; b.d = beat_data(8'hE0, i, fid); b.k = 8'hFF; b.l = (i == 3);
      exp_q.push_back(b);
      send_beat(b.d, b.k, b.l, 0);
      if (i == 1) begin
        checks++; if (m_tvalid !== 3'b001) begin errors++; $display("FAIL high_latency: m_tvalid %b want 001", m_tvalid); end
        checks++; if (s_tready !== 1'b0) begin errors++; $display("FAIL high_flush_tready: got %b want 0", s_tready); end
      end
    end
    fid++;
    wait_drain(ok);
    checks++; if (!ok || got_q.size() != 4) begin errors++; $display("FAIL high_beats: got %0d want 4", got_q.size()); end
    for (int i = 0; i < 4 && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL high_beat%0d: got %h want %h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (frame_count !== {4'd0, 4'd0, 4'd1}) begin errors++; $display("FAIL high_counts: got %h want 001", frame_count); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    do_reset();
    send_frame(8'h60, 4, 8'hFF, 0);
    send_frame(8'h00, 3, 8'hFF, 0);
    wait_drain(ok);
    checks++; if (!ok || got_q.size() != 7) begin errors++; $display("FAIL b2b_beats: got %0d want 7", got_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL b2b_beat%0d: got %h want %h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (frame_count !== {4'd1, 4'd1, 4'd0}) begin errors++; $display("FAIL b2b_counts: got %h want 110", frame_count); end
  endtask

  task automatic test_short_frame();
    bit ok;
    do_reset();
    send_frame(8'hE0, 1, 8'hFF, 0);
    checks++; if (short_frame !== 1'b1) begin errors++; $display("FAIL short_pulse: got %b want 1", short_frame); end
    @(posedge clk); #1;
    checks++; if (short_frame !== 1'b0) begin errors++; $display("FAIL short_pulse_width: got %b want 0", short_frame); end
    send_frame(8'hE0, 2, 8'h7F, 0);
    wait_drain(ok);
    checks++; if (!ok || got_q.size() != 3) begin errors++; $display("FAIL short_beats: got %0d want 3", got_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL short_beat%0d: got %h want %h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (s_tready !== 1'b1) begin errors++; $display("FAIL short_header_return: tready %b want 1", s_tready); end
    checks++; if (short_seen - short_base !== 2) begin errors++; $display("FAIL short_count: got %0d want 2", short_seen - short_base); end
    checks++; if (frame_count !== {4'd2, 4'd0, 4'd0}) begin errors++; $display("FAIL short_counts: got %h want 200", frame_count); end
  endtask

  task automatic test_backpressure();
    bit ok;
    int c;
    do_reset();
    rdy_manual = 1'b1;
    m_tready = 3'b110;
    fork
      send_frame(8'hA0, 5, 8'hFF, 0);
      begin
        for (c = 0; c < 50 && !m_tvalid[0]; c++) begin @(posedge clk); #1; end
        checks++; if (c >= 50) begin errors++; $display("FAIL bp_valid_timeout: m_tvalid %b want 001", m_tvalid); end
        for (int i = 0; i < 10; i++) begin
          @(posedge clk); #1;
          checks++; if (s_tready !== 1'b0) begin errors++; $display("FAIL bp_s_tready cyc%0d: got %b want 0", i, s_tready); end
          checks++; if (m_tvalid !== 3'b001) begin errors++; $display("FAIL bp_m_tvalid cyc%0d: got %b want 001", i, m_tvalid); end
          checks++; if (m_tdata[63:0] !== exp_q[0].d) begin errors++; $display("FAIL bp_data cyc%0d: got %h want %h", i, m_tdata[63:0], exp_q[0].d); end
        end
        m_tready = 3'b111;
        rdy_manual = 1'b0;
      end
    join
    wait_drain(ok);
    checks++; if (!ok || got_q.size() != 5) begin errors++; $display("FAIL bp_beats: got %0d want 5", got_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL bp_beat%0d: got %h want %h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (frame_count !== {4'd0, 4'd0, 4'd1}) begin errors++; $display("FAIL bp_counts: got %h want 001", frame_count); end
  endtask

  task automatic test_reset_mid_frame();
    bit ok;
    do_reset();
    send_beat(beat_data(8'h20, 0, 99), 8'hFF, 1'b0, 0);
    send_beat(beat_data(8'h20, 1, 99), 8'hFF, 1'b0, 0);
    rst = 1'b1;
    #1;
    checks++; if (m_tvalid !== 3'b000) begin errors++; $display("FAIL midrst_m_tvalid: got %b want 000", m_tvalid); end
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    checks++; if (frame_count !== '0) begin errors++; $display("FAIL midrst_counts: got %h want 0", frame_count); end
    checks++; if (m_tvalid !== 3'b000) begin errors++; $display("FAIL midrst_after_valid: got %b want 000", m_tvalid); end
    checks++; if (got_q.size() != 0) begin errors++; $display("FAIL midrst_leak: got %0d beats want 0", got_q.size()); end
    @(posedge clk); #1;
    send_frame(8'hE0, 4, 8'hFF, 0);
    wait_drain(ok);
    checks++; if (!ok || got_q.size() != 4) begin errors++; $display("FAIL midrst_beats: got %0d want 4", got_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL midrst_beat%0d: got %h want %h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (frame_count !== {4'd0, 4'd0, 4'd1}) begin errors++; $display("FAIL midrst_final_counts: got %h want 001", frame_count); end
  endtask

  task automatic test_counter_wrap();
    bit ok;
    do_reset();
    for (int i = 0; i < 15; i++) send_frame(8'h00, 1, 8'hFF, 0);
    wait_drain(ok);
    checks++; if (frame_count[11:8] !== 4'd15) begin errors++; $display("FAIL wrap_pre: got %0d want 15", frame_count[11:8]); end
    send_frame(8'h00, 1, 8'hFF, 0);
    wait_drain(ok);
    checks++; if (frame_count[11:8] !== 4'd0) begin errors++; $display("FAIL wrap_zero: got %0d want 0", frame_count[11:8]); end
    checks++; if (!ok || got_q.size() != 16) begin errors++; $display("FAIL wrap_beats: got %0d want 16", got_q.size()); end
    checks++; if (short_seen - short_base !== 16) begin errors++; $display("FAIL wrap_short: got %0d want 16", short_seen - short_base); end
  endtask

  task automatic test_random();
    bit ok;
    logic [KW-1:0] kl;
    do_reset();
    rdy_rand = 1'b1;
    for (int f = 0; f < 40; f++) begin
      case ($urandom_range(0, 2))
        0:       kl = 8'hFF;
        1:       kl = 8'h7F;
        default: kl = 8'h0F;
      endcase
      send_frame(8'($urandom_range(0, 255)), $urandom_range(1, 7), kl, 2);
    end
    wait_drain(ok);
    rdy_rand = 1'b0;
    checks++; if (!ok || got_q.size() != exp_q.size()) begin errors++; $display("FAIL rand_beats: got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand_beat%0d: got %h want %h", i, got_q[i], exp_q[i]); end
    end
    for (int k = 0; k < 3; k++) begin
      checks++; if (frame_count[k*CW +: CW] !== CW'(cnt_m[k])) begin errors++; $display("FAIL rand_count%0d: got %0d want %0d", k, frame_count[k*CW +: CW], cnt_m[k]); end
    end
    checks++; if (short_seen - short_base !== short_exp) begin errors++; $display("FAIL rand_short: got %0d want %0d", short_seen - short_base, short_exp); end
    checks++; if (viol !== viol_base) begin errors++; $display("FAIL rand_protocol: %0d violations want 0", viol - viol_base); end
  endtask

  initial begin
    m_tready = 3'b111;
    test_reset();
    test_high_priority();
    test_back_to_back();
    test_short_frame();
    test_backpressure();
    test_reset_mid_frame();
    test_counter_wrap();
    test_random();
    checks++; if (viol !== 0) begin errors++; $display("FAIL protocol_total: %0d violations want 0", viol); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/packet_priority_classifier.md
PACKET_PRIORITY_CLASSIFIER -- requirements
Module: packet_priority_classifier

Interface
REQ-001 SHALL have parameter AXIS_DATA_WIDTH, default 64, meaning the stream data width in bits (multiple of 8).
REQ-002 SHALL have parameter AXIS_KEEP_WIDTH, default AXIS_DATA_WIDTH/8, meaning the tkeep width.
REQ-003 SHALL have parameter PRIO_BYTE_OFFSET, default 15, meaning the frame byte index of the priority byte (IPv4 TOS); the derived HDR_BEATS = PRIO_BYTE_OFFSET/AXIS_KEEP_WIDTH + 1 SHALL be <= 8.
REQ-004 SHALL have parameter HIGH_THRESH, default 5, meaning the minimum precedence for class 0.
REQ-005 SHALL have parameter MID_THRESH, default 3, meaning the minimum precedence for class 1.
REQ-006 SHALL have parameter DEFAULT_CLASS, default 2, meaning the class used for short frames.
REQ-007 SHALL have parameter COUNT_WIDTH, default 32, meaning the width of each frame counter.
REQ-008 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-009 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-010 SHALL have ports s_axis_tdata/tkeep/tvalid/tready/tlast, with directions in/in/in/out/in and widths AXIS_DATA_WIDTH/AXIS_KEEP_WIDTH/1/1/1: the single ingress stream.
REQ-011 SHALL have ports m_axis_priority_fifo_tdata/tkeep/tvalid/tready/tlast, with directions out/out/out/in/out and widths 3*AXIS_DATA_WIDTH/3*AXIS_KEEP_WIDTH/3/3/3: three packed egress streams, where slice k is class k (0 is highest) and feeds the priority FIFO k input.
REQ-012 SHALL have port status_frame_count, output, 3*COUNT_WIDTH bits: the per-class count of forwarded frames, packed with slice k for class k.
REQ-013 SHALL have port status_short_frame, output, 1 bit: a one-cycle pulse for each frame that ends before the priority byte.

Function
REQ-014 SHALL implement states HEADER, FLUSH and PASS, with a header buffer of HDR_BEATS beats (tdata, tkeep, tlast) and a write index wr_cnt.
REQ-015 In HEADER, s_axis_tready SHALL be 1 and every accepted beat SHALL be written to buffer[wr_cnt], with wr_cnt incremented.
REQ-016 Classification SHALL trigger in HEADER when the accepted beat has wr_cnt==HDR_BEATS-1 or tlast=1; on trigger the block SHALL register sel, reset rd_cnt to 0, and enter FLUSH.
REQ-017 The priority byte SHALL be byte PRIO_BYTE_OFFSET%AXIS_KEEP_WIDTH of beat HDR_BEATS-1, and precedence SHALL be its bits [7:5].
REQ-018 Class SHALL be 0 if precedence>=HIGH_THRESH, otherwise 1 if precedence>=MID_THRESH, otherwise 2.
REQ-019 If the priority byte is not received, or its tkeep bit is 0, the class SHALL be DEFAULT_CLASS and status_short_frame SHALL pulse in the cycle after the trigger.
REQ-020 In FLUSH, s_axis_tready SHALL be 0, m tvalid[sel] SHALL be 1 carrying buffer[rd_cnt], and rd_cnt SHALL advance on m tready[sel].
REQ-021 After the last buffered beat is handshaken, FLUSH SHALL go to HEADER (wr_cnt=0) if that beat had tlast=1, and otherwise to PASS.
REQ-022 In PASS, the path SHALL be combinational: m tvalid[sel]=s_axis_tvalid, s_axis_tready=m tready[sel], and tdata/tkeep/tlast pass through.
REQ-023 In PASS, a tlast handshake SHALL return the block to HEADER with wr_cnt=0.
REQ-024 Latency SHALL be one cycle from the trigger beat handshake to the first m tvalid.
REQ-025 Throughput SHALL be one beat per cycle in PASS, with a bubble of HDR_BEATS cycles per frame.
REQ-026 Only m tvalid[sel] SHALL ever be asserted, and all three tdata/tkeep/tlast slices SHALL carry the same value.
REQ-027 Once asserted, tvalid SHALL be held with stable data until the handshake; egress backpressure SHALL stall without loss or reordering.
REQ-028 A frame SHALL never be split across classes, and sel SHALL be constant from the trigger until the frame's tlast handshake.
REQ-029 status_frame_count[k] SHALL increment by 1 on each tlast handshake on egress k, wrapping at 2^COUNT_WIDTH.
REQ-030 A single-beat frame SHALL trigger in HEADER, be flushed, and return to HEADER, with no PASS cycle.

Reset
REQ-031 While rst=1, the state SHALL be HEADER, wr_cnt/rd_cnt/sel SHALL be 0, and buffer contents SHALL be don't-care.
REQ-032 While rst=1, outputs SHALL be: s_axis_tready=0, m tvalid=3'b000, status_frame_count all 0, and status_short_frame=0.
REQ-033 A reset mid-frame SHALL discard the partial frame, and the first beat after reset release SHALL be treated as a frame start.

Verification
REQ-034 The bench SHALL apply a 64-bit, 4-beat frame with beat1 tdata[63:56]=0xE0 and expect all 4 beats on port 0 only, status_frame_count[0]=1, and first m tvalid[0] 1 cycle after beat1 is accepted.
REQ-035 The bench SHALL apply back-to-back frames with TOS 0x60 then 0x00 and expect the first on port 1 and the second on port 2, with intact beats/tlast and counts (0,1,1).
REQ-036 The bench SHALL apply a 1-beat frame with tlast=1 and expect it on port 2, a status_short_frame pulse, and a return to HEADER.
REQ-037 The bench SHALL hold m tready[0]=0 for 10 cycles during a TOS=0xA0 frame and expect s_axis_tready=0, stable m data, and no beat lost or duplicated after release.
REQ-038 The bench SHALL assert rst=1 for 1 cycle after beat 2 of a 6-beat frame and expect m tvalid=0 with counters 0; the next frame (TOS 0xE0) SHALL be routed correctly to port 0.
REQ-039 The bench SHALL apply randomized frame lengths, TOS values, and tvalid/tready stalls and check against a scoreboard per class, including that 2^COUNT_WIDTH frames wrap the counter to 0.
